pc_ctrl: RTL and testbench

Program-counter controller for the basic processor: the consumer side of the branch-judge interface. It holds the fetch PC, advances it each cycle, redirects it on a registered branch-taken (`bj`) from the branch unit or an unconditional jump from decode, and squashes the wrong-path instructions already in flight. It sits between the branch unit / decoder and instruction memory, and counts taken redirects for debug.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_ctrl_if.sv | 36 +++
 rtl/pc_ctrl_flush_timer.sv | 43 ++++
 rtl/pc_ctrl.sv | 84 ++++++++
 tb/tb_pc_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter controller.
//   PC_W        default PC / target width (instruction-word addressed)
//   RESET_PC    PC value loaded by reset
//   pc_state_t  controller state: RUN (normal fetch) / FLUSH (squashing wrong path)
//   flush_cnt_t width of the wrong-path squash counter (1..7 instructions)
package pc_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef enum logic {RUN, FLUSH} pc_state_t;

    typedef logic [2:0] flush_cnt_t;

endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: branch-judge / fetch bundle between the branch unit + decoder
// (master) and the PC controller (slave).
//   stall        hold PC (memory/hazard stall)
//   bj           branch taken, qualifies br_target
//   br_target    branch destination
//   jump         unconditional jump from decode, qualifies jump_target
//   jump_target  jump destination
//   pc           current fetch address (registered)
//   flush        squash in-flight decode/execute instruction (registered)
//   redirect     one-cycle pulse after a target was loaded
//   taken_cnt    saturating count of accepted redirects
interface pc_ctrl_if #(
    parameter int PC_W = 16
);

    logic            stall;
    logic            bj;
    logic [PC_W-1:0] br_target;
    logic            jump;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] pc;
    logic            flush;
    logic            redirect;
    logic [15:0]     taken_cnt;

    modport master (
        output stall, bj, br_target, jump, jump_target,
        input  pc, flush, redirect, taken_cnt
    );

    modport slave (
        input  stall, bj, br_target, jump, jump_target,
        output pc, flush, redirect, taken_cnt
    );

endinterface

// File: rtl/pc_ctrl_flush_timer.sv
// flush_timer: down-counter tracking how many wrong-path instructions are
// still to be squashed after a redirect.
//   clk, rst  clock, synchronous active-high reset
//   load      redirect accepted: start a new squash window of LOAD_VAL
//   dec       one instruction advanced (unstalled cycle) while busy
//   busy      squash window open (counter nonzero)
//   last      the next decrement closes the window
//   flush     registered squash strobe for decode/execute
module flush_timer
    import pc_pkg::*;
#(
    parameter flush_cnt_t LOAD_VAL = 3'd2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic busy,
    output logic last,
    output logic flush
);

    flush_cnt_t cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            flush <= 1'b0;
        end else if (load) begin
            cnt   <= LOAD_VAL;
            flush <= 1'b1;
        end else if (dec && busy) begin
            cnt   <= cnt - 3'd1;
            // flush follows the post-decrement count so it drops with the
            // final squashed instruction, not one cycle later
            flush <= (cnt != 3'd1);
        end
    end

    assign busy = (cnt != '0);
    assign last = (cnt == 3'd1);

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-PC controller. Advances the PC, redirects on a taken branch
// (bj) or decode jump, squashes the wrong-path instructions behind each
// redirect and counts accepted redirects.
//   clk, rst   clock, synchronous active-high reset
//   bus        pc_ctrl_if slave: stall/bj/br_target/jump/jump_target in,
//              pc/flush/redirect/taken_cnt out (all outputs registered)
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int              PC_W         = pc_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC     = PC_W'(pc_pkg::RESET_PC),
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst,
    pc_ctrl_if.slave bus
);

    pc_state_t       state;
    logic [PC_W-1:0] pc_q;
    logic            redirect_q;
    logic [15:0]     taken_q;
    logic            accept;
    logic [PC_W-1:0] tgt;
    logic            tmr_busy;
    logic            tmr_last;

    // Redirect requests are only honoured in RUN: anything arriving during
    // FLUSH comes from an instruction being squashed. bj outranks jump.
    always_comb begin
        accept = (state == RUN) && (bus.bj || bus.jump);
        tgt    = bus.bj ? bus.br_target : bus.jump_target;
    end

    flush_timer #(
        .LOAD_VAL (flush_cnt_t'(FLUSH_CYCLES))
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .dec   (tmr_busy && !bus.stall),
        .busy  (tmr_busy),
        .last  (tmr_last),
        .flush (bus.flush)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            taken_q    <= '0;
        end else begin
            redirect_q <= 1'b0;
            case (state)
                RUN: begin
                    // redirect beats stall
                    if (accept) begin
                        pc_q       <= tgt;
                        redirect_q <= 1'b1;
                        state      <= FLUSH;
                        if (taken_q != 16'hFFFF)
                            taken_q <= taken_q + 16'd1;
                    end else if (!bus.stall) begin
                        pc_q <= pc_q + PC_W'(1);
                    end
                end
                FLUSH: begin
                    // stalls freeze the squash window: it counts instructions
                    if (!bus.stall) begin
                        pc_q <= pc_q + PC_W'(1);
                        if (tmr_last)
                            state <= RUN;
                    end
                end
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.redirect  = redirect_q;
    assign bus.taken_cnt = taken_q;

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model: PC as an integer, remaining squash budget in instructions
    int m_pc;
    int m_left;
    int m_taken;
    bit m_redir;

    pc_ctrl_if #(.PC_W(16)) bus ();

    pc_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        if (rst) begin
            m_pc = 0; m_left = 0; m_redir = 0; m_taken = 0;
        end else begin
            m_redir = 0;
            if (m_left == 0 && (bus.bj || bus.jump)) begin
                m_pc    = bus.bj ? int'(bus.br_target) : int'(bus.jump_target);
                m_left  = FC;
                m_redir = 1;
                if (m_taken < 65535) m_taken++;
            end else if (!bus.stall) begin
                m_pc = (m_pc + 1) % 65536;
                if (m_left > 0) m_left--;
            end
        end
    endtask

    // one clock edge; model sees the same inputs as the DUT, outputs settle by #1
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.bj = 0; bus.jump = 0;
        bus.br_target = '0; bus.jump_target = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; tick(); tick();
        n_checks++; if (bus.pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", bus.pc); end
        n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
        n_checks++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b want 0", bus.redirect); end
        n_checks++; if (bus.taken_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_taken: got %h want 0", bus.taken_cnt); end
        rst = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (bus.pc !== 16'(i)) begin n_fail++; $display("FAIL reset_incr[%0d]: got %h want %h", i, bus.pc, 16'(i)); end
        end
    endtask

    task automatic test_taken_branch();
        logic [15:0] e_pc [3] = '{16'h0040, 16'h0041, 16'h0042};
        logic        e_fl [3] = '{1'b1, 1'b1, 1'b0};
        logic        e_rd [3] = '{1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (bus.pc !== 16'h0005) begin n_fail++; $display("FAIL branch_pre_pc: got %h want 0005", bus.pc); end
        bus.bj = 1; bus.br_target = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            tick(); bus.bj = 0;
            n_checks++; if (bus.pc !== e_pc[i]) begin n_fail++; $display("FAIL branch_pc[%0d]: got %h want %h", i, bus.pc, e_pc[i]); end
            n_checks++; if (bus.flush !== e_fl[i]) begin n_fail++; $display("FAIL branch_flush[%0d]: got %b want %b", i, bus.flush, e_fl[i]); end
            n_checks++; if (bus.redirect !== e_rd[i]) begin n_fail++; $display("FAIL branch_redirect[%0d]: got %b want %b", i, bus.redirect, e_rd[i]); end
        end
        n_checks++; if (bus.taken_cnt !== 16'd1) begin n_fail++; $display("FAIL branch_taken: got %0d want 1", bus.taken_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] tgts [3] = '{16'h0040, 16'h0080, 16'h00C0};
        logic [15:0] e_pc [4] = '{16'h0040, 16'h0041, 16'h0042, 16'h0043};
        do_reset();
        tick(); tick();
        bus.bj = 1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) bus.br_target = tgts[i]; else bus.bj = 0;
            tick();
            n_checks++; if (bus.pc !== e_pc[i]) begin n_fail++; $display("FAIL shadow_pc[%0d]: got %h want %h", i, bus.pc, e_pc[i]); end
        end
        n_checks++; if (bus.taken_cnt !== 16'd1) begin n_fail++; $display("FAIL shadow_taken: got %0d want 1", bus.taken_cnt); end
    endtask

    task automatic test_collision();
        logic [15:0] e_pc [5] = '{16'h0010, 16'h0010, 16'h0010, 16'h0011, 16'h0012};
        logic        e_fl [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        e_rd [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        tick();
        bus.bj = 1; bus.br_target = 16'h0010;
        bus.jump = 1; bus.jump_target = 16'h0020;
        bus.stall = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.bj = 0; bus.jump = 0;
            bus.stall = (i < 2);
            n_checks++; if (bus.pc !== e_pc[i]) begin n_fail++; $display("FAIL collide_pc[%0d]: got %h want %h", i, bus.pc, e_pc[i]); end
            n_checks++; if (bus.flush !== e_fl[i]) begin n_fail++; $display("FAIL collide_flush[%0d]: got %b want %b", i, bus.flush, e_fl[i]); end
            n_checks++; if (bus.redirect !== e_rd[i]) begin n_fail++; $display("FAIL collide_redirect[%0d]: got %b want %b", i, bus.redirect, e_rd[i]); end
        end
        n_checks++; if (bus.taken_cnt !== 16'd1) begin n_fail++; $display("FAIL collide_taken: got %0d want 1", bus.taken_cnt); end
    endtask

    task automatic test_wrap();
        logic [15:0] e_pc [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        do_reset();
        bus.jump = 1; bus.jump_target = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            tick(); bus.jump = 0;
            n_checks++; if (bus.pc !== e_pc[i]) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, bus.pc, e_pc[i]); end
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        bus.bj = 1; bus.br_target = 16'h0040;
        tick(); bus.bj = 0;
        n_checks++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL rmf_pre_flush: got %b want 1", bus.flush); end
        rst = 1; tick(); rst = 0;
        n_checks++; if (bus.pc !== 16'h0000) begin n_fail++; $display("FAIL rmf_pc: got %h want 0000", bus.pc); end
        n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL rmf_flush: got %b want 0", bus.flush); end
        n_checks++; if (bus.taken_cnt !== 16'd0) begin n_fail++; $display("FAIL rmf_taken: got %0d want 0", bus.taken_cnt); end
        bus.bj = 1; bus.br_target = 16'h0077;
        tick(); bus.bj = 0;
        n_checks++; if (bus.pc !== 16'h0077) begin n_fail++; $display("FAIL rmf_bj_pc: got %h want 0077", bus.pc); end
        n_checks++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL rmf_bj_redirect: got %b want 1", bus.redirect); end
        n_checks++; if (bus.taken_cnt !== 16'd1) begin n_fail++; $display("FAIL rmf_bj_taken: got %0d want 1", bus.taken_cnt); end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst               = ($urandom_range(63) == 0);
            bus.stall         = ($urandom_range(3) == 0);
            bus.bj            = ($urandom_range(3) == 0);
            bus.jump          = ($urandom_range(3) == 0);
            bus.br_target     = 16'($urandom);
            bus.jump_target   = 16'($urandom);
            tick();
            n_checks++;
            if (bus.pc !== 16'(m_pc) || bus.flush !== (m_left != 0) ||
                bus.redirect !== m_redir || bus.taken_cnt !== 16'(m_taken)) begin
                n_fail++;
                if (errs++ < 10)
                    $display("FAIL random[%0d]: got pc=%h fl=%b rd=%b tc=%0d want pc=%h fl=%b rd=%b tc=%0d",
                             c, bus.pc, bus.flush, bus.redirect, bus.taken_cnt,
                             16'(m_pc), (m_left != 0), m_redir, m_taken);
            end
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        m_pc = 0; m_left = 0; m_taken = 0; m_redir = 0;
        test_reset();
        test_taken_branch();
        test_back_to_back();
        test_collision();
        test_wrap();
        test_reset_mid_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
